// File: rtl/cla_seq_adder.sv
// Sequential WIDTH-bit adder: one 16-bit carry-lookahead slice reused per cycle, low slice first.
// Valid/ready on both sides; reports carry-out and two's-complement overflow.

module CLA_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);
    logic [15:0] g, p, c;
    logic [3:0]  gg, pg;
    logic [4:0]  gc;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar j = 0; j < 4; j++) begin : g_grp
        assign gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
        assign pg[j] = &p[4*j +: 4];

        assign c[4*j]   = gc[j];
        assign c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
        assign c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
        assign c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                        | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end

    // Second-level lookahead across the four 4-bit groups.
    assign gc[0] = cin;
    assign gc[1] = gg[0] | (pg[0] & cin);
    assign gc[2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cin);
    assign gc[3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0]) | (pg[2] & pg[1] & pg[0] & cin);
    assign gc[4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1]) | (pg[3] & pg[2] & pg[1] & gg[0])
                 | (pg[3] & pg[2] & pg[1] & pg[0] & cin);

    assign sum  = p ^ c;
    assign cout = gc[4];
endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready=1
// CALC  | adding slice k this cycle
// DONE  | result held on outputs until out_ready
module cla_seq_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / 16;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic            carry;
    logic [KW-1:0]   k;
    logic [15:0]     a_sl, b_sl, s_sl;
    logic            c_sl;
    logic            accept, last;

    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int i = 0; i < N; i++) begin
            if (k == KW'(i)) begin
                a_sl = a_reg[16*i +: 16];
                b_sl = b_reg[16*i +: 16];
            end
        end
    end

    CLA_16bit u_slice (
        .a    (a_sl),
        .b    (b_sl),
        .cin  (carry),
        .sum  (s_sl),
        .cout (c_sl)
    );

    assign last = (k == KW'(N-1));

    always_comb begin
        state_next = state;
        in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
        accept     = in_valid && in_ready;
        case (state)
            IDLE: if (accept) state_next = CALC;
            CALC: if (last)   state_next = DONE;
            DONE: if (out_ready) state_next = accept ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= (state_next == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            k     <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            a_reg <= a;
            b_reg <= b;
            carry <= cin;
            k     <= '0;
        end else if (state == CALC) begin
            for (int i = 0; i < N; i++) begin
                if (k == KW'(i)) sum[16*i +: 16] <= s_sl;
            end
            carry <= c_sl;
            k     <= k + 1'b1;
            if (last) begin
                cout <= c_sl;
                // MSB operands xor new sum MSB recovers the carry into the MSB.
                ovf  <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ s_sl[15] ^ c_sl;
            end
        end
    end
endmodule

// File: tb/tb_cla_seq_adder.sv
// Directed self-checking bench for cla_seq_adder (WIDTH=32, two slices per add).

module tb_cla_seq_adder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] a, b;
    logic        cin;
    logic        out_valid, out_ready;
    logic [31:0] sum;
    logic        cout, ovf;

    int n_checks = 0;
    int n_fail   = 0;

    cla_seq_adder #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Drive one operand set from IDLE and return edges from accept to out_valid (-1 on timeout).
    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b, input logic op_c,
                          output int lat);
        @(negedge clk);
        a = op_a; b = op_b; cin = op_c; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready_during: got %b expected 1", in_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++;
        if (sum !== 32'h0) begin n_fail++; $display("FAIL reset_sum: got %h expected 00000000", sum); end
        n_checks++;
        if ({cout, ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_cout_ovf: got %b expected 00", {cout, ovf}); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_inter_slice();
        int lat;
        run_op(32'h0000FFFF, 32'h00000001, 1'b0, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL inter_slice_latency: got %0d expected 2", lat); end
        n_checks++;
        if (sum !== 32'h00010000) begin n_fail++; $display("FAIL inter_slice_sum: got %h expected 00010000", sum); end
        n_checks++;
        if ({cout, ovf} !== 2'b00) begin n_fail++; $display("FAIL inter_slice_flags: got %b expected 00", {cout, ovf}); end
        consume();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL inter_slice_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_full_propagate();
        int lat;
        run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, lat);
        n_checks++;
        if (lat !== 2) begin n_fail++; $display("FAIL propagate_latency: got %0d expected 2", lat); end
        n_checks++;
        if (sum !== 32'h00000000) begin n_fail++; $display("FAIL propagate_sum: got %h expected 00000000", sum); end
        n_checks++;
        if ({cout, ovf} !== 2'b10) begin n_fail++; $display("FAIL propagate_flags: got %b expected 10", {cout, ovf}); end
        consume();
    endtask

    task automatic test_overflow();
        int lat;
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, lat);
        n_checks++;
        if (sum !== 32'h80000000 || lat !== 2) begin
            n_fail++; $display("FAIL ovf_pos_sum: got %h lat %0d expected 80000000 lat 2", sum, lat);
        end
        n_checks++;
        if ({cout, ovf} !== 2'b01) begin n_fail++; $display("FAIL ovf_pos_flags: got %b expected 01", {cout, ovf}); end
        consume();
        run_op(32'h80000000, 32'h80000000, 1'b0, lat);
        n_checks++;
        if (sum !== 32'h00000000 || lat !== 2) begin
            n_fail++; $display("FAIL ovf_neg_sum: got %h lat %0d expected 00000000 lat 2", sum, lat);
        end
        n_checks++;
        if ({cout, ovf} !== 2'b11) begin n_fail++; $display("FAIL ovf_neg_flags: got %b expected 11", {cout, ovf}); end
        consume();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [31:0] op_a [3];
        logic [31:0] op_b [3];
        logic [31:0] exp_s [3];
        logic [1:0]  exp_f [3];
        op_a[0] = 32'h00000010; op_b[0] = 32'h00000020; exp_s[0] = 32'h00000030; exp_f[0] = 2'b00;
        op_a[1] = 32'hFFFF0000; op_b[1] = 32'h00010000; exp_s[1] = 32'h00000000; exp_f[1] = 2'b10;
        op_a[2] = 32'h00000001; op_b[2] = 32'h00000001; exp_s[2] = 32'h00000002; exp_f[2] = 2'b00;

        run_op(32'h00000005, 32'h00000003, 1'b0, lat);
        // Backpressure: new operands offered but must be ignored.
        a = 32'hDEADBEEF; b = 32'h01010101; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL bp_hold_ctrl[%0d]: got valid %b ready %b expected valid 1 ready 0", i, out_valid, in_ready);
            end
            n_checks++;
            if (sum !== 32'h00000008 || {cout, ovf} !== 2'b00) begin
                n_fail++; $display("FAIL bp_hold_data[%0d]: got %h flags %b expected 00000008 flags 00", i, sum, {cout, ovf});
            end
        end

        for (int i = 0; i < 3; i++) begin
            a = op_a[i]; b = op_b[i]; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready); end
            @(posedge clk);
            lat = -1;
            for (int j = 1; j <= 10; j++) begin
                @(posedge clk);
                #1;
                if (out_valid === 1'b1) begin lat = j; break; end
            end
            n_checks++;
            if (lat !== 2) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d expected 2", i, lat); end
            n_checks++;
            if (sum !== exp_s[i] || {cout, ovf} !== exp_f[i]) begin
                n_fail++; $display("FAIL b2b_result[%0d]: got %h flags %b expected %h flags %b", i, sum, {cout, ovf}, exp_s[i], exp_f[i]);
            end
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_drain: got valid %b ready %b expected valid 0 ready 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_calc();
        int lat;
        int seen;
        @(negedge clk);
        a = 32'h12345678; b = 32'h11111111; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || sum !== 32'h0 || {cout, ovf} !== 2'b00 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_reset_values: got valid %b sum %h flags %b ready %b expected 0 00000000 00 1",
                               out_valid, sum, {cout, ovf}, in_ready);
        end
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (out_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d valid cycles expected 0", seen); end
        run_op(32'h00000001, 32'h00000002, 1'b0, lat);
        n_checks++;
        if (sum !== 32'h00000003 || lat !== 2) begin
            n_fail++; $display("FAIL post_abort_sum: got %h lat %0d expected 00000003 lat 2", sum, lat);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_inter_slice();
        test_full_propagate();
        test_overflow();
        test_back_to_back();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
